// File: rtl/bomb_controller.sv
// bomb_controller: countdown controller for the bomb detonator.
// It takes debounced button levels and detects their rising edges internally.
// It runs the SET / ARMED / DEFUSED / EXPLODED state machine.
// Time is kept in BCD so the 7-segment decoder reads tens/ones directly.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   btn_inc           debounced level: increment set time
//   btn_start         debounced level: arm, or restart after the end
//   btn_defuse        debounced level: defuse while armed
//   tens, ones        BCD digits of the remaining or set time (registered)
//   armed, defused,
//   exploded          one-hot state indicators, all zero in SET (registered)
//   blink             LED blink drive (registered)
//
// Optional feature: define BOMB_INC_REPEAT_EN to enable auto-repeat on a
// held btn_inc while in SET (one extra increment every REPEAT_CYCLES).
module bomb_controller #(
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int INIT_TIME     = 30,
  parameter int MAX_TIME      = 99,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_start,
  input  logic       btn_defuse,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       armed,
  output logic       defused,
  output logic       exploded,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_SET,
    ST_ARMED,
    ST_DEFUSED,
    ST_EXPLODED
  } state_t;

  localparam int PW = $clog2(TICK_CYCLES);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] TICK_HALF = PW'(TICK_CYCLES / 2);

  localparam logic [3:0] INIT_TENS = 4'(INIT_TIME / 10);
  localparam logic [3:0] INIT_ONES = 4'(INIT_TIME % 10);
  localparam logic [3:0] MAX_TENS  = 4'(MAX_TIME / 10);
  localparam logic [3:0] MAX_ONES  = 4'(MAX_TIME % 10);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [3:0]    tens_nxt;
  logic [3:0]    ones_nxt;
  logic          armed_nxt;
  logic          defused_nxt;
  logic          exploded_nxt;
  logic          blink_nxt;

  // Edge detection. The press pulses are registered, so a level first
  // sampled high at edge k acts on the state machine at edge k+1.
  logic prev_inc;
  logic prev_start;
  logic prev_defuse;
  logic press_inc;
  logic press_start;
  logic press_defuse;

  logic rep_fire;
  logic inc_evt;
  logic time_zero;
  logic time_max;
  logic time_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_inc     <= 1'b0;
      prev_start   <= 1'b0;
      prev_defuse  <= 1'b0;
      press_inc    <= 1'b0;
      press_start  <= 1'b0;
      press_defuse <= 1'b0;
    end else begin
      prev_inc     <= btn_inc;
      prev_start   <= btn_start;
      prev_defuse  <= btn_defuse;
      press_inc    <= btn_inc & ~prev_inc;
      press_start  <= btn_start & ~prev_start;
      press_defuse <= btn_defuse & ~prev_defuse;
    end
  end

`ifdef BOMB_INC_REPEAT_EN
  // Auto-repeat: counts cycles of continuous hold (level high on two
  // consecutive samples) while in SET. Each wrap adds one increment.
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          holding;

  assign holding  = (state == ST_SET) && btn_inc && prev_inc;
  assign rep_fire = holding && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!holding || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign inc_evt   = press_inc | rep_fire;
  assign time_zero = (tens == 4'd0) && (ones == 4'd0);
  assign time_one  = (tens == 4'd0) && (ones == 4'd1);
  assign time_max  = (tens == MAX_TENS) && (ones == MAX_ONES);

  // State, time and prescaler register; status outputs are registered
  // copies of the decoded next state so every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SET;
      pre      <= '0;
      tens     <= INIT_TENS;
      ones     <= INIT_ONES;
      armed    <= 1'b0;
      defused  <= 1'b0;
      exploded <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre      <= pre_nxt;
      tens     <= tens_nxt;
      ones     <= ones_nxt;
      armed    <= armed_nxt;
      defused  <= defused_nxt;
      exploded <= exploded_nxt;
      blink    <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tens_nxt  = tens;
    ones_nxt  = ones;
    // The prescaler only runs in ARMED; every other path leaves it cleared,
    // which also covers the clear on arming and on restart.
    pre_nxt   = '0;

    unique case (state)
      ST_SET: begin
        // Start is judged on the pre-increment time; a simultaneous
        // increment is dropped.
        if (press_start && !time_zero) begin
          state_nxt = ST_ARMED;
        end else if (press_start) begin
          // Start at 00 is ignored, and the increment is still dropped.
        end else if (inc_evt) begin
          if (time_max) begin
            tens_nxt = 4'd0;
            ones_nxt = 4'd0;
          end else if (ones == 4'd9) begin
            tens_nxt = tens + 4'd1;
            ones_nxt = 4'd0;
          end else begin
            ones_nxt = ones + 4'd1;
          end
        end
      end

      ST_ARMED: begin
        // Defuse beats a coincident final tick: time stays frozen.
        if (press_defuse) begin
          state_nxt = ST_DEFUSED;
        end else if (pre == TICK_LAST) begin
          if (ones == 4'd0) begin
            tens_nxt = tens - 4'd1;
            ones_nxt = 4'd9;
          end else begin
            ones_nxt = ones - 4'd1;
          end
          if (time_one) begin
            state_nxt = ST_EXPLODED;
          end
        end else begin
          pre_nxt = pre + 1'b1;
        end
      end

      ST_DEFUSED, ST_EXPLODED: begin
        if (press_start) begin
          state_nxt = ST_SET;
          tens_nxt  = INIT_TENS;
          ones_nxt  = INIT_ONES;
        end
      end

      default: begin
        state_nxt = ST_SET;
      end
    endcase

    armed_nxt    = (state_nxt == ST_ARMED);
    defused_nxt  = (state_nxt == ST_DEFUSED);
    exploded_nxt = (state_nxt == ST_EXPLODED);
    blink_nxt    = ((state_nxt == ST_ARMED) && (pre_nxt < TICK_HALF)) ||
                   (state_nxt == ST_EXPLODED);
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Testbench for bomb_controller: directed scenarios plus randomized button
// activity, all compared against a behavioural model that keeps the time as
// a plain integer and counts seconds with integer arithmetic.
module tb_bomb_controller;

  localparam int T    = 10;
  localparam int INIT = 3;
  localparam int MAX  = 12;
  localparam int R    = 4;

  localparam int M_SET      = 0;
  localparam int M_ARMED    = 1;
  localparam int M_DEFUSED  = 2;
  localparam int M_EXPLODED = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_defuse = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       armed;
  logic       defused;
  logic       exploded;
  logic       blink;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_st;
  int m_time;
  int m_pre;
  int m_hold;
  bit m_prev_i, m_prev_s, m_prev_d;
  bit m_pi, m_ps, m_pd;

  bomb_controller #(
    .TICK_CYCLES  (T),
    .INIT_TIME    (INIT),
    .MAX_TIME     (MAX),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc   (btn_inc),
    .btn_start (btn_start),
    .btn_defuse(btn_defuse),
    .tens      (tens),
    .ones      (ones),
    .armed     (armed),
    .defused   (defused),
    .exploded  (exploded),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] status();
    return {28'd0, armed, defused, exploded, blink};
  endfunction

  task automatic model_reset();
    m_st = M_SET; m_time = INIT; m_pre = 0; m_hold = 0;
    m_prev_i = 0; m_prev_s = 0; m_prev_d = 0;
    m_pi = 0; m_ps = 0; m_pd = 0;
  endtask

  // One clock edge of the model, given the button levels sampled there.
  task automatic model_edge(input bit i, input bit s, input bit d);
    bit fire;
    bit inc_ev;
    fire = 0;
`ifdef BOMB_INC_REPEAT_EN
    if (m_st == M_SET && i && m_prev_i) begin
      m_hold++;
      fire = (m_hold % R == 0);
    end else begin
      m_hold = 0;
    end
`endif
    inc_ev = m_pi | fire;
    case (m_st)
      M_SET: begin
        if (m_ps) begin
          if (m_time != 0) begin
            m_st = M_ARMED;
            m_pre = 0;
          end
        end else if (inc_ev) begin
          m_time = (m_time == MAX) ? 0 : m_time + 1;
        end
      end
      M_ARMED: begin
        if (m_pd) begin
          m_st = M_DEFUSED;
          m_pre = 0;
        end else if (m_pre == T - 1) begin
          m_pre = 0;
          m_time = m_time - 1;
          if (m_time == 0) m_st = M_EXPLODED;
        end else begin
          m_pre++;
        end
      end
      default: begin
        if (m_ps) begin
          m_st = M_SET;
          m_time = INIT;
          m_pre = 0;
        end
      end
    endcase
    m_pi = i && !m_prev_i;
    m_ps = s && !m_prev_s;
    m_pd = d && !m_prev_d;
    m_prev_i = i; m_prev_s = s; m_prev_d = d;
  endtask

  task automatic check_model(input string tag);
    int exp_st;
    bit bl;
    bl = (m_st == M_EXPLODED) || (m_st == M_ARMED && m_pre < T / 2);
    exp_st = ((m_st == M_ARMED) ? 8 : 0) | ((m_st == M_DEFUSED) ? 4 : 0) |
             ((m_st == M_EXPLODED) ? 2 : 0) | (bl ? 1 : 0);
    check({tag, ".tens"}, {28'd0, tens}, m_time / 10);
    check({tag, ".ones"}, {28'd0, ones}, m_time % 10);
    check({tag, ".status"}, status(), exp_st);
  endtask

  // Literal expectation for the directed scenarios.
  task automatic expect_out(input string tag, input int t, input int o, input logic [3:0] st);
    check({tag, ".tens"}, {28'd0, tens}, t);
    check({tag, ".ones"}, {28'd0, ones}, o);
    check({tag, ".status"}, status(), {28'd0, st});
  endtask

  // Called at a negedge: drive levels, clock once, compare at next negedge.
  task automatic cyc(input bit i, input bit s, input bit d, input string tag = "cyc");
    btn_inc = i; btn_start = s; btn_defuse = d;
    @(posedge clk);
    model_edge(i, s, d);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic press(input int which);
    cyc(which == 0, which == 1, which == 2);
    cyc(0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must change
  // without waiting for a clock.
  task automatic do_reset(input string tag);
    btn_inc = 0; btn_start = 0; btn_defuse = 0;
    rst_n = 1'b0;
    #2;
    expect_out(tag, 0, 3, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("reset");
    idle(3);
    expect_out("idle", 0, 3, 4'b0000);

    // Three increments
    for (int k = 0; k < 3; k++) press(0);
    expect_out("inc3", 0, 6, 4'b0000);

    // Arm from 03 and let it run out
    do_reset("reset2");
    press(1);
    expect_out("armed", 0, 3, 4'b1001);
    idle(10);
    expect_out("tick1", 0, 2, 4'b1001);
    idle(10);
    expect_out("tick2", 0, 1, 4'b1001);
    idle(10);
    expect_out("boom", 0, 0, 4'b0011);
    idle(20);
    expect_out("boom_hold", 0, 0, 4'b0011);

    // Wrap at MAX, start ignored at 00
    do_reset("reset3");
    for (int k = 0; k < 9; k++) press(0);
    expect_out("at_max", 1, 2, 4'b0000);
    press(0);
    expect_out("wrap", 0, 0, 4'b0000);
    press(1);
    expect_out("start00", 0, 0, 4'b0000);
    press(0);
    expect_out("after_wrap", 0, 1, 4'b0000);

    // Defuse 15 cycles after arming, then restart
    do_reset("reset4");
    press(1);
    idle(13);
    press(2);
    expect_out("defuse", 0, 2, 4'b0100);
    idle(50);
    expect_out("frozen", 0, 2, 4'b0100);
    press(1);
    expect_out("restart", 0, 3, 4'b0000);

    // Defuse coincident with the final tick
    do_reset("reset5");
    for (int k = 0; k < 11; k++) press(0);
    expect_out("at01", 0, 1, 4'b0000);
    press(1);
    idle(8);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    expect_out("race", 0, 1, 4'b0100);
    idle(30);
    expect_out("race_hold", 0, 1, 4'b0100);

    // Held btn_inc
    do_reset("reset6");
    for (int k = 0; k < 13; k++) cyc(1, 0, 0);
`ifdef BOMB_INC_REPEAT_EN
    expect_out("hold", 0, 7, 4'b0000);
`else
    expect_out("hold", 0, 4, 4'b0000);
`endif
    idle(2);

    // Randomized button activity with one mid-run asynchronous reset
    do_reset("reset7");
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset("mid_reset");
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 63) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
